// File: rtl/aesl_deadlock_proc_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_proc_monitor_if
// Brief    : Dependence-propagation and token-ring signals of one
//            per-process deadlock monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface aesl_deadlock_proc_monitor_if #(
  parameter int PROC_NUM = 4
);
  logic                         proc_blocked;
  logic [PROC_NUM-1:0]          dep_vec;
  logic [PROC_NUM-1:0]          in_dep_vld;
  logic [PROC_NUM*PROC_NUM-1:0] in_dep_data;
  logic                         out_dep_vld;
  logic [PROC_NUM-1:0]          out_dep_data;
  logic                         dl_detect_in;
  logic                         origin;
  logic [PROC_NUM-1:0]          token_in;
  logic                         token_clear;
  logic [PROC_NUM-1:0]          token_out;
  logic                         dl_detect_out;

  // Environment side: drives process status, peer sets and report-unit controls
  modport master (
    output proc_blocked, dep_vec, in_dep_vld, in_dep_data,
           dl_detect_in, origin, token_in, token_clear,
    input  out_dep_vld, out_dep_data, token_out, dl_detect_out
  );

  // Monitor side
  modport slave (
    input  proc_blocked, dep_vec, in_dep_vld, in_dep_data,
           dl_detect_in, origin, token_in, token_clear,
    output out_dep_vld, out_dep_data, token_out, dl_detect_out
  );
endinterface
`default_nettype wire

// File: rtl/aesl_deadlock_proc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : aesl_deadlock_proc_monitor
// Brief    : Per-process deadlock monitor. Propagates waits-on reachability
//            sets and flags self-reachability; in report mode acts as one
//            hop of the token ring that walks each dependence cycle.
// Revision : 1.0 - initial release
// ============================================================================
module aesl_deadlock_proc_monitor #(
  parameter int PROC_NUM   = 4,
  parameter int MY_PROC_ID = 0
) (
  input  logic                        dl_clock,
  input  logic                        dl_reset,
  aesl_deadlock_proc_monitor_if.slave bus
);

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]          r_state;
  logic [PROC_NUM-1:0] r_reach;
  logic                r_out_dep_vld;
  logic [PROC_NUM-1:0] r_out_dep_data;
  logic                r_self_dl;
  logic                r_origin_flag;
  logic [PROC_NUM-1:0] r_succ_oh;

  logic [PROC_NUM-1:0] w_dep_vec_m;
  logic [PROC_NUM-1:0] w_reach_next;
  logic [PROC_NUM-1:0] w_succ;
  logic [PROC_NUM-1:0] w_succ_oh;
  logic                w_self_dl;
  logic                w_token_any;

  // Own bit of dep_vec never counts as a dependence
  always_comb begin
    w_dep_vec_m             = bus.dep_vec;
    w_dep_vec_m[MY_PROC_ID] = 1'b0;
  end

  // Next reach set: direct dependences plus the sets of valid peers we wait on
  always_comb begin
    w_reach_next = w_dep_vec_m;
    for (int k = 0; k < PROC_NUM; k++) begin
      if (w_dep_vec_m[k] && bus.in_dep_vld[k]) begin
        w_reach_next = w_reach_next | bus.in_dep_data[k*PROC_NUM +: PROC_NUM];
      end
    end
    if (!bus.proc_blocked) begin
      w_reach_next = '0;
    end
  end

  // Successors: peers we wait on whose published set already contains us
  always_comb begin
    w_succ = '0;
    for (int k = 0; k < PROC_NUM; k++) begin
      w_succ[k] = w_dep_vec_m[k] & bus.in_dep_vld[k]
                & bus.in_dep_data[k*PROC_NUM + MY_PROC_ID];
    end
  end

  // Isolate the lowest-indexed successor so the token goes to exactly one peer
  assign w_succ_oh   = w_succ & (~w_succ + PROC_NUM'(1));
  assign w_self_dl   = r_reach[MY_PROC_ID] & bus.proc_blocked;
  assign w_token_any = |bus.token_in;

  // Reachability pipeline: one hop per cycle, running in every state
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_reach        <= '0;
      r_out_dep_vld  <= 1'b0;
      r_out_dep_data <= '0;
      r_self_dl      <= 1'b0;
    end else begin
      r_reach        <= w_reach_next;
      r_out_dep_vld  <= bus.proc_blocked;
      r_out_dep_data <= r_reach;
      r_self_dl      <= w_self_dl;
    end
  end

  // Report-mode FSM; leaving report mode outranks token_clear, which outranks
  // the per-state transition
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_state       <= ST_MONITOR;
      r_origin_flag <= 1'b0;
      r_succ_oh     <= '0;
    end else if ((r_state != ST_MONITOR) && !bus.dl_detect_in) begin
      r_state       <= ST_MONITOR;
      r_origin_flag <= 1'b0;
    end else if ((r_state != ST_MONITOR) && bus.token_clear) begin
      r_state       <= ST_WAIT;
      r_origin_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_MONITOR: begin
          if (bus.dl_detect_in) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.origin) begin
            r_origin_flag <= 1'b1;
            r_succ_oh     <= w_succ_oh;
            r_state       <= ST_HOLD;
          end else if (w_token_any) begin
            r_succ_oh     <= w_succ_oh;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: r_state <= ST_DONE;
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_MONITOR;
      endcase
    end
  end

  // Outputs decoded from state; the closing token is acknowledged combinationally
  always_comb begin
    bus.dl_detect_out = 1'b0;
    bus.token_out     = '0;
    case (r_state)
      ST_MONITOR: bus.dl_detect_out = r_self_dl;
      ST_HOLD: begin
        bus.dl_detect_out = 1'b1;
        bus.token_out     = r_succ_oh;
      end
      ST_DONE: bus.dl_detect_out = r_origin_flag & w_token_any;
      default: bus.dl_detect_out = 1'b0;
    endcase
  end

  assign bus.out_dep_vld  = r_out_dep_vld;
  assign bus.out_dep_data = r_out_dep_data;

endmodule
`default_nettype wire

// File: tb/tb_aesl_deadlock_proc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_aesl_deadlock_proc_monitor
// Brief    : Directed vector bench for aesl_deadlock_proc_monitor,
//            PROC_NUM=4, MY_PROC_ID=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aesl_deadlock_proc_monitor;

  logic dl_clock = 1'b0;
  logic dl_reset = 1'b0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  aesl_deadlock_proc_monitor_if #(.PROC_NUM(4)) bus ();

  aesl_deadlock_proc_monitor #(.PROC_NUM(4), .MY_PROC_ID(1)) dut (
    .dl_clock (dl_clock),
    .dl_reset (dl_reset),
    .bus      (bus)
  );

  always #5 dl_clock = ~dl_clock;

  typedef struct {
    logic        pb;
    logic [3:0]  dep;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        dl_in;
    logic        org;
    logic [3:0]  tin;
    logic        tclr;
    logic        e_dl;
    logic [3:0]  e_tok;
    logic        e_vld;
    logic [3:0]  e_data;
  } vec_t;

  function automatic vec_t mk(input logic pb, input logic [3:0] dep,
                              input logic [3:0] vld, input logic [15:0] data,
                              input logic dl_in, input logic org,
                              input logic [3:0] tin, input logic tclr,
                              input logic e_dl, input logic [3:0] e_tok,
                              input logic e_vld, input logic [3:0] e_data);
    vec_t v;
    v.pb = pb; v.dep = dep; v.vld = vld; v.data = data;
    v.dl_in = dl_in; v.org = org; v.tin = tin; v.tclr = tclr;
    v.e_dl = e_dl; v.e_tok = e_tok; v.e_vld = e_vld; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic e_dl, input logic [3:0] e_tok,
                            input logic e_vld, input logic [3:0] e_data);
    chk({nm, ".dl_detect_out"}, {3'b0, bus.dl_detect_out}, {3'b0, e_dl});
    chk({nm, ".token_out"},     bus.token_out,             e_tok);
    chk({nm, ".out_dep_vld"},   {3'b0, bus.out_dep_vld},   {3'b0, e_vld});
    chk({nm, ".out_dep_data"},  bus.out_dep_data,          e_data);
  endtask

  // Drive at the falling edge, compare 1 time unit later, before the next rising edge
  task automatic apply(input vec_t v, input string nm);
    @(negedge dl_clock);
    bus.proc_blocked = v.pb;
    bus.dep_vec      = v.dep;
    bus.in_dep_vld   = v.vld;
    bus.in_dep_data  = v.data;
    bus.dl_detect_in = v.dl_in;
    bus.origin       = v.org;
    bus.token_in     = v.tin;
    bus.token_clear  = v.tclr;
    #1;
    check_outs(nm, v.e_dl, v.e_tok, v.e_vld, v.e_data);
  endtask

  vec_t tbl[$];

  initial begin
    // S: blocked on peer 2, whose set contains us -> 2-process cycle
    // T: blocked on peers 0 and 2, both sets contain us
    // U: blocked on peer 2 with no valid peer data -> no successor
    tbl.push_back(mk(0,4'b0000,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0000,1,4'b0110));
    tbl.push_back(mk(0,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0000,1,4'b0110));
    tbl.push_back(mk(0,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,0,4'b0110));
    tbl.push_back(mk(0,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000));
    // own bit in dep_vec is masked
    tbl.push_back(mk(1,4'b0010,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000));
    tbl.push_back(mk(1,4'b0010,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    tbl.push_back(mk(1,4'b0010,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    // peer data without its valid is not merged
    tbl.push_back(mk(1,4'b0100,4'b0000,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0000,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0000,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0100));
    tbl.push_back(mk(0,4'b0000,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,1,4'b0100));
    tbl.push_back(mk(0,4'b0000,4'b0000,16'h0000, 0,0,4'b0000,0, 0,4'b0000,0,4'b0100));
    // origin walk on S
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 0,4'b0000,1,4'b0000));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,1,4'b0000,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0100,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0100,0, 1,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0100,1, 1,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 0,4'b0000,1,4'b0110));
    // non-origin hop after token_clear: returning token is not acknowledged
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b1000,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0100,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0100,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0110));
    tbl.push_back(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0000,1,4'b0110));

    bus.proc_blocked = 1'b0; bus.dep_vec = '0; bus.in_dep_vld = '0; bus.in_dep_data = '0;
    bus.dl_detect_in = 1'b0; bus.origin = 1'b0; bus.token_in = '0; bus.token_clear = 1'b0;

    @(negedge dl_clock);
    #1;
    check_outs("reset_state", 1'b0, 4'b0000, 1'b0, 4'b0000);
    @(posedge dl_clock);
    #2 dl_reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Non-origin hop, two successors -> lowest one gets the token
    apply(mk(1,4'b0101,4'b0101,16'h0202, 1,0,4'b0000,0, 1,4'b0000,1,4'b0110), "hop_enter");
    apply(mk(1,4'b0101,4'b0101,16'h0202, 1,0,4'b1000,0, 0,4'b0000,1,4'b0110), "hop_wait");
    apply(mk(1,4'b0101,4'b0101,16'h0202, 1,0,4'b0000,0, 1,4'b0001,1,4'b0111), "hop_hold");
    apply(mk(1,4'b0101,4'b0101,16'h0202, 1,0,4'b0001,0, 0,4'b0000,1,4'b0111), "hop_done_ignore");
    apply(mk(1,4'b0101,4'b0101,16'h0202, 1,0,4'b0000,1, 0,4'b0000,1,4'b0111), "hop_clear");

    // origin and token together -> origin; no successor -> token_out stays 0
    apply(mk(1,4'b0100,4'b0000,16'h0000, 1,1,4'b0010,0, 0,4'b0000,1,4'b0111), "both_wait");
    apply(mk(1,4'b0100,4'b0000,16'h0000, 1,0,4'b0000,0, 1,4'b0000,1,4'b0111), "both_hold");
    apply(mk(1,4'b0100,4'b0000,16'h0000, 1,0,4'b0100,0, 1,4'b0000,1,4'b0100), "both_done_close");
    apply(mk(1,4'b0100,4'b0000,16'h0000, 1,0,4'b0000,1, 0,4'b0000,1,4'b0100), "both_clear");

    // Asynchronous reset in the middle of ST_HOLD
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,1,4'b0000,0, 0,4'b0000,1,4'b0100), "rst_wait");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0100,1,4'b0100), "rst_hold");
    dl_reset = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 4'b0000, 1'b0, 4'b0000);
    @(posedge dl_clock);
    #2 dl_reset = 1'b1;
    apply(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,0,4'b0000), "rst_after0");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 0,4'b0000,1,4'b0000), "rst_after1");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0000,1,4'b0110), "rst_after2");

    // dl_detect_in dropping during ST_HOLD returns to monitor and clears origin_flag
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0000,1,4'b0110), "exit_enter");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,1,4'b0000,0, 0,4'b0000,1,4'b0110), "exit_origin");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0100,1,4'b0110), "exit_hold");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 0,0,4'b0000,0, 1,4'b0000,1,4'b0110), "exit_monitor");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0000,1,4'b0110), "exit_reenter");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b1000,0, 0,4'b0000,1,4'b0110), "exit_wait");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0000,0, 1,4'b0100,1,4'b0110), "exit_hold2");
    apply(mk(1,4'b0100,4'b0100,16'h0200, 1,0,4'b0100,0, 0,4'b0000,1,4'b0110), "exit_flag_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
